// File: rtl/horner_evaluator_if.sv
// Operand/result handshake bundle between the expression-solver top level
// (master) and the Horner evaluator (slave).
interface horner_evaluator_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] result;
    logic             done;
    logic             busy;
    logic             ovf;

    modport master (
        output start, a, b, c, x,
        input  result, done, busy, ovf
    );

    modport slave (
        input  start, a, b, c, x,
        output result, done, busy, ovf
    );
endinterface

// File: rtl/horner_evaluator.sv
// Sequential evaluator of y = (a*x + b)*x + c on signed WIDTH-bit operands.
// One multiply or add per cycle through a single accumulator; every step
// wraps to WIDTH bits and sets a sticky overflow flag when it leaves range.
module horner_evaluator #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    horner_evaluator_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL1 = 3'd1,
        S_ADD1 = 3'd2,
        S_MUL2 = 3'd3,
        S_ADD2 = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   a_q, b_q, c_q, x_q;
    logic [WIDTH-1:0]   acc_q;
    logic               ovf_acc_q;
    logic [WIDTH-1:0]   result_q;
    logic               done_q;
    logic               busy_q;
    logic               ovf_q;

    // Shared datapath: one full-precision multiplier and one adder.
    logic [WIDTH-1:0]   mul_lhs, add_rhs;
    logic [2*WIDTH-1:0] mul_d;
    logic [WIDTH:0]     add_d;
    logic               mul_ovf, add_ovf;

    // Select operands for the current step and flag out-of-range results.
    always_comb begin
        mul_lhs = (state_q == S_MUL1) ? a_q : acc_q;
        add_rhs = (state_q == S_ADD1) ? b_q : c_q;
        // Sign-extending both factors to 2*WIDTH makes the unsigned product's
        // low 2*WIDTH bits equal the exact signed product.
        mul_d   = {{WIDTH{mul_lhs[WIDTH-1]}}, mul_lhs} * {{WIDTH{x_q[WIDTH-1]}}, x_q};
        add_d   = {acc_q[WIDTH-1], acc_q} + {add_rhs[WIDTH-1], add_rhs};
        // In range iff all bits above the truncated sign bit replicate it.
        mul_ovf = (mul_d[2*WIDTH-1:WIDTH-1] != {(WIDTH+1){mul_d[WIDTH-1]}});
        add_ovf = (add_d[WIDTH] != add_d[WIDTH-1]);
    end

    // Control FSM with registered handshake outputs and accumulator steps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            c_q       <= '0;
            x_q       <= '0;
            acc_q     <= '0;
            ovf_acc_q <= 1'b0;
            result_q  <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        a_q       <= bus.a;
                        b_q       <= bus.b;
                        c_q       <= bus.c;
                        x_q       <= bus.x;
                        ovf_acc_q <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= S_MUL1;
                    end
                end
                S_MUL1, S_MUL2: begin
                    acc_q     <= mul_d[WIDTH-1:0];
                    ovf_acc_q <= ovf_acc_q | mul_ovf;
                    state_q   <= (state_q == S_MUL1) ? S_ADD1 : S_ADD2;
                end
                S_ADD1: begin
                    acc_q     <= add_d[WIDTH-1:0];
                    ovf_acc_q <= ovf_acc_q | add_ovf;
                    state_q   <= S_MUL2;
                end
                S_ADD2: begin
                    result_q  <= add_d[WIDTH-1:0];
                    ovf_q     <= ovf_acc_q | add_ovf;
                    done_q    <= 1'b1;
                    busy_q    <= 1'b0;
                    state_q   <= S_DONE;
                end
                S_DONE: begin
                    // start is deliberately not looked at here.
                    done_q    <= 1'b0;
                    state_q   <= S_IDLE;
                end
                default: begin
                    done_q    <= 1'b0;
                    busy_q    <= 1'b0;
                    state_q   <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.result = result_q;
    assign bus.done   = done_q;
    assign bus.busy   = busy_q;
    assign bus.ovf    = ovf_q;

endmodule
